// File: rtl/imem_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
//   Shared constants and types for the instruction-fetch controller.
//   - MEM_ADDR_WIDTH / MEM_WORD_WIDTH : IMem address and word widths
//   - IMEM_RESET_PC                   : first fetch address after reset
//   - INSTR_BYTES                     : bytes per instruction (PC step)
//   - fetch_state_e                   : fetch sequencer states
// -----------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

    localparam int          MEM_ADDR_WIDTH = 32;
    localparam int          MEM_WORD_WIDTH = 32;
    localparam logic [31:0] IMEM_RESET_PC  = 32'h0000_0000;
    localparam int          INSTR_BYTES    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_fetch_buf
//   Two-entry FIFO holding {pc, instr} pairs between IMem and decode.
//   Ports:
//     i_clk, i_rst  : clock, asynchronous active-high reset (to empty)
//     i_push/i_data : write one entry (caller guarantees no overflow)
//     i_pop         : retire the head (caller guarantees not empty)
//     i_flush       : drop all entries; wins over push/pop
//     o_count       : number of valid entries (0..2)
//     o_head        : oldest entry
// -----------------------------------------------------------------------------
module imem_fetch_ctrl_fetch_buf #(
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    output logic [1:0]        o_count,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    // With two entries, a full buffer has r_wr_ptr == r_rd_ptr; a push with a
    // simultaneous pop overwrites the slot being read out this cycle, which is
    // safe because the head moves to the other slot at the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Owns the PC, issues one word-aligned IMem read per cycle (1-cycle read
//   latency), buffers returned {pc, instr} pairs in a 2-entry queue toward
//   decode, handles branch redirects and raises a sticky fetch fault.
//   Ports:
//     i_clk, i_rst                  : clock, asynchronous active-high reset
//     i_en                          : fetch enable (0 = stop issuing)
//     i_redirect_valid/i_redirect_pc: branch/jump redirect
//     o_imem_req/o_imem_addr        : IMem read request (addr 0 when idle)
//     i_imem_addr_err/i_imem_data   : IMem response, cycle after request
//     o_if_valid/i_if_ready         : queue head handshake to decode
//     o_if_instr/o_if_pc            : queue head contents (0 when empty)
//     o_fault/o_fault_pc            : sticky fetch fault and faulting address
//     o_state                       : current sequencer state (debug)
//
//   Handshake: decode takes the head in any cycle where o_if_valid and
//   i_if_ready are both high; o_if_valid never depends on i_if_ready, and the
//   head stays stable until taken, flushed by a redirect, or reset.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int               ADDR_W   = MEM_ADDR_WIDTH,
    parameter int               WORD_W   = MEM_WORD_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IMEM_RESET_PC)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_addr_err,
    input  logic [WORD_W-1:0] i_imem_data,
    output logic              o_if_valid,
    input  logic              i_if_ready,
    output logic [WORD_W-1:0] o_if_instr,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic              o_fault,
    output logic [ADDR_W-1:0] o_fault_pc,
    output fetch_state_e      o_state
);

    localparam int               ENTRY_W = ADDR_W + WORD_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;
    logic              r_inflight;
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_pc;

    logic [1:0]         w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_redir_bad;
    logic               w_resp_err;
    logic               w_can_run;
    logic               w_issue;
    logic [2:0]         w_occ;

    // ------------------------------------------------------------------
    // Response handling. A redirect in the response cycle drops the
    // response (data and error alike): no issue happens in a redirect
    // cycle, so this is the only response a redirect can flush.
    // ------------------------------------------------------------------
    assign w_valid     = (w_count != 2'd0);
    assign w_pop       = w_valid & i_if_ready;
    assign w_redir_bad = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);
    assign w_push      = r_inflight & ~i_redirect_valid & ~i_imem_addr_err;
    assign w_resp_err  = r_inflight & ~i_redirect_valid &  i_imem_addr_err;

    // Entries the queue will hold after this cycle, counting the response
    // landing now. A new read may only go out if its response has room.
    assign w_occ = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};

    // IDLE with en high issues in the same cycle it moves to FETCH, so the
    // first instruction is at the decode boundary two cycles after en rises.
    // A faulting response also blocks issue, so nothing younger than the
    // fault is ever requested.
    assign w_can_run = i_en & ((r_state == IDLE) | (r_state == FETCH));
    assign w_issue   = ~i_rst & w_can_run & ~i_redirect_valid & ~w_resp_err
                     & (w_occ < 3'd2);

    imem_fetch_ctrl_fetch_buf #(
        .DATA_W (ENTRY_W)
    ) u_fetch_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_data  ({r_tag, i_imem_data}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // ------------------------------------------------------------------
    // Sequencer: next state. Redirect outranks a faulting response.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_en)        w_state_nxt = FETCH;
            FETCH:   if (!i_en)       w_state_nxt = DRAIN;
            DRAIN:   if (!r_inflight) w_state_nxt = IDLE;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = IDLE;
        endcase
        if (w_resp_err) begin
            w_state_nxt = FAULT;
        end
        if (i_redirect_valid) begin
            if (w_redir_bad) begin
                w_state_nxt = FAULT;
            end else if (r_state == FAULT) begin
                w_state_nxt = i_en ? FETCH : IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, PC, inflight tracking and fault registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= r_pc;
            end
            if (i_redirect_valid) begin
                r_pc <= i_redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
            // An aligned redirect clears the fault; a misaligned one records
            // its own target as the faulting address.
            if (i_redirect_valid) begin
                r_fault    <= w_redir_bad;
                r_fault_pc <= w_redir_bad ? i_redirect_pc : '0;
            end else if (w_resp_err) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_imem_req  = w_issue;
    assign o_imem_addr = w_issue ? r_pc : '0;
    assign o_if_valid  = w_valid;
    assign o_if_pc     = w_valid ? w_head[ENTRY_W-1:WORD_W] : '0;
    assign o_if_instr  = w_valid ? w_head[WORD_W-1:0] : '0;
    assign o_fault     = r_fault;
    assign o_fault_pc  = r_fault_pc;
    assign o_state     = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Drives imem_fetch_ctrl against a small IMem model (word i = 0x1000_0000+i,
//   out-of-range addresses flag addr_err). Delivered instructions are checked
//   against an expected address stream: consecutive words starting at the
//   reset PC or at the last aligned redirect target.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    localparam int          AW        = 32;
    localparam int          WW        = 32;
    localparam logic [31:0] IMEM_SIZE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_addr_err = 1'b0;
    logic [WW-1:0] imem_data = '0;
    logic          if_valid;
    logic          if_ready;
    logic [WW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          fault;
    logic [AW-1:0] fault_pc;
    fetch_state_e  state;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_req    = 0;
    int base_acc;
    int base_req;

    logic [AW-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    imem_fetch_ctrl dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_en             (en),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_addr_err  (imem_addr_err),
        .i_imem_data      (imem_data),
        .o_if_valid       (if_valid),
        .i_if_ready       (if_ready),
        .o_if_instr       (if_instr),
        .o_if_pc          (if_pc),
        .o_fault          (fault),
        .o_fault_pc       (fault_pc),
        .o_state          (state)
    );

    // ---------------- IMem model ----------------
    function automatic logic [31:0] img(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_req && (imem_addr < IMEM_SIZE) && (imem_addr[1:0] == 2'b00)) begin
            imem_addr_err <= 1'b0;
            imem_data     <= img(imem_addr);
        end else begin
            imem_addr_err <= imem_req;
            imem_data     <= '0;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: sample at the falling edge, score any handshake,
    // update the expected stream on a redirect, return just after the
    // next rising edge so the caller can drive the following cycle.
    task automatic cyc();
        logic [AW-1:0] e;
        @(negedge clk);
        if (imem_req) n_req++;
        if (if_valid && if_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            chk("sb_pc", 64'(if_pc), 64'(e));
            chk("sb_instr", 64'(if_instr), 64'(img(e)));
            exp_q.push_back(e + 32'd4);
            n_acc++;
        end
        if (redirect_valid) begin
            exp_q.delete();
            if (redirect_pc[1:0] == 2'b00) exp_q.push_back(redirect_pc);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst            = 1'b1;
        en             = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        exp_q.push_back(32'(IMEM_RESET_PC));
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_req",      64'(imem_req), 64'd0);
        chk("rst_addr",     64'(imem_addr), 64'd0);
        chk("rst_valid",    64'(if_valid), 64'd0);
        chk("rst_instr",    64'(if_instr), 64'd0);
        chk("rst_pc",       64'(if_pc), 64'd0);
        chk("rst_fault",    64'(fault), 64'd0);
        chk("rst_fault_pc", 64'(fault_pc), 64'd0);
        chk("rst_state",    64'(state), 64'(IDLE));
        rst = 1'b0;
        base_req = n_req;
        cyc(); cyc();
        chk("idle_no_req", 64'(n_req - base_req), 64'd0);

        // Streaming: first read in the cycle en rises, head two cycles later
        if_ready = 1'b1;
        en       = 1'b1;
        #1;
        chk("first_req",      64'(imem_req), 64'd1);
        chk("first_addr",     64'(imem_addr), 64'(IMEM_RESET_PC));
        chk("first_valid_c0", 64'(if_valid), 64'd0);
        cyc();
        chk("first_valid_c1", 64'(if_valid), 64'd0);
        cyc();
        chk("first_valid_c2", 64'(if_valid), 64'd1);
        chk("first_pc",       64'(if_pc), 64'(IMEM_RESET_PC));
        chk("first_instr",    64'(if_instr), 64'h1000_0000);
        base_acc = n_acc;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stream_valid", 64'(if_valid), 64'd1);
        end
        chk("stream_count", 64'(n_acc - base_acc), 64'd10);

        // Backpressure: queue fills, requests stop, order preserved
        if_ready = 1'b0;
        base_req = n_req;
        base_acc = n_acc;
        repeat (5) cyc();
        chk("bp_no_req",  64'(n_req - base_req), 64'd0);
        chk("bp_no_acc",  64'(n_acc - base_acc), 64'd0);
        chk("bp_valid",   64'(if_valid), 64'd1);
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp_resume_valid", 64'(if_valid), 64'd1);
            cyc();
        end
        chk("bp_resume_count", 64'(n_acc - base_acc), 64'd6);

        // Redirect to 0x40 with a read in flight and the queue filling
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        #1;
        chk("redir_flush_valid", 64'(if_valid), 64'd0);
        chk("redir_issue_req",   64'(imem_req), 64'd1);
        chk("redir_issue_addr",  64'(imem_addr), 64'h40);
        cyc();
        chk("redir_valid_c2", 64'(if_valid), 64'd0);
        cyc();
        chk("redir_head_pc", 64'(if_pc), 64'h40);
        repeat (4) cyc();

        // Misaligned redirect: fault, no further requests
        redirect_valid = 1'b1;
        redirect_pc    = 32'h41;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_fault",    64'(fault), 64'd1);
        chk("mis_fault_pc", 64'(fault_pc), 64'h41);
        chk("mis_state",    64'(state), 64'(FAULT));
        chk("mis_valid",    64'(if_valid), 64'd0);
        base_req = n_req;
        repeat (6) cyc();
        chk("mis_no_req", 64'(n_req - base_req), 64'd0);

        // Aligned redirect to 0 clears the fault and restarts streaming
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("clr_fault",    64'(fault), 64'd0);
        chk("clr_fault_pc", 64'(fault_pc), 64'd0);
        chk("clr_state",    64'(state), 64'(FETCH));
        chk("clr_addr",     64'(imem_addr), 64'h0);
        base_acc = n_acc;
        repeat (8) cyc();
        chk("clr_count", 64'(n_acc - base_acc), 64'd6);

        // Range error: last word delivered, next address faults
        redirect_valid = 1'b1;
        redirect_pc    = IMEM_SIZE - 32'd4;
        cyc();
        redirect_valid = 1'b0;
        base_acc = n_acc;
        base_req = n_req;
        repeat (6) cyc();
        chk("range_one_instr", 64'(n_acc - base_acc), 64'd1);
        chk("range_req_count", 64'(n_req - base_req), 64'd2);
        chk("range_fault",     64'(fault), 64'd1);
        chk("range_fault_pc",  64'(fault_pc), 64'(IMEM_SIZE));
        chk("range_state",     64'(state), 64'(FAULT));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        repeat (5) cyc();

        // Enable drop: DRAIN then IDLE with the queue kept
        en       = 1'b0;
        if_ready = 1'b0;
        base_req = n_req;
        cyc();
        chk("en_drain", 64'(state), 64'(DRAIN));
        cyc();
        chk("en_idle",  64'(state), 64'(IDLE));
        repeat (3) cyc();
        chk("en_kept_valid", 64'(if_valid), 64'd1);
        chk("en_no_req",     64'(n_req - base_req), 64'd0);
        if_ready = 1'b1;
        base_acc = n_acc;
        cyc(); cyc();
        chk("en_kept_count", 64'(n_acc - base_acc), 64'd2);
        chk("en_empty",      64'(if_valid), 64'd0);
        en = 1'b1;
        repeat (6) cyc();

        // Reset mid-stream: outputs return to zero, restart at reset PC
        rst = 1'b1;
        #1;
        chk("mrst_req",      64'(imem_req), 64'd0);
        chk("mrst_addr",     64'(imem_addr), 64'd0);
        chk("mrst_valid",    64'(if_valid), 64'd0);
        chk("mrst_instr",    64'(if_instr), 64'd0);
        chk("mrst_pc",       64'(if_pc), 64'd0);
        chk("mrst_fault_pc", 64'(fault_pc), 64'd0);
        chk("mrst_state",    64'(state), 64'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'(IMEM_RESET_PC));
        base_acc = n_acc;
        repeat (6) cyc();
        chk("mrst_restart_count", 64'(n_acc - base_acc), 64'd4);

        // Random ready / enable / aligned redirects
        base_acc = n_acc;
        for (int i = 0; i < 300; i++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            en       = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'($urandom_range(0, 511)) << 2;
            end else begin
                redirect_valid = 1'b0;
            end
            cyc();
        end
        redirect_valid = 1'b0;
        chk("rand_delivered", 64'(n_acc - base_acc != 0), 64'd1);
        chk("rand_no_fault",  64'(fault), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
